// File: rtl/data_chk_pkg.sv
// Shared definitions for the data/checksum stream: widths, beat layout,
// checksum field position and the verifier's hold-stage states.
package data_chk_pkg;

  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;
  localparam int ID_W   = 6;
  localparam int CHK_W  = 32;

  // The received checksum occupies the low word of the checksum beat.
  localparam int CHK_LSB = 0;

  // Number of 32-bit words summed per data beat.
  localparam int WORDS = DATA_W / CHK_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [ID_W-1:0]   id;
    logic              last;
  } beat_t;

  // EMPTY: no data beat parked; HOLD: one data beat parked awaiting its successor.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } chk_state_t;

endpackage

// File: rtl/data_chk_sum512.sv
// Combinational keep-masked sum of the sixteen 32-bit words of one beat,
// modulo 2^32. Shared with the upstream checksum generator.
module data_chk_sum512
  import data_chk_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [KEEP_W-1:0] keep,
  output logic [CHK_W-1:0]  sum
);

  logic [DATA_W-1:0] masked;

  // Bytes with a cleared keep bit contribute zero to the sum.
  generate
    for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_mask
      assign masked[gi*8 +: 8] = keep[gi] ? data[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // Wrap-around addition of all masked words.
  always_comb begin
    sum = '0;
    for (int w = 0; w < WORDS; w++) begin
      sum = sum + masked[w*CHK_W +: CHK_W];
    end
  end

endmodule

// File: rtl/data_chk_verifier.sv
// Checksum verifier: recomputes each segment's checksum, strips the checksum
// beat, moves `last` onto the final data beat and emits a status pulse.
// Optional saturating failure counter enabled by DATA_CHK_VERIFIER_ERR_CNT_EN.
module data_chk_verifier
  import data_chk_pkg::*;
#(
  parameter int MAX_DATA_BEATS = 4
`ifdef DATA_CHK_VERIFIER_ERR_CNT_EN
  ,
  parameter int ERR_CNT_W = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic [ID_W-1:0]   in_id,
  input  logic              in_last,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KEEP_W-1:0] out_keep,
  output logic [ID_W-1:0]   out_id,
  output logic              out_last,
  output logic              status_valid,
  output logic              status_ok,
  output logic [ID_W-1:0]   status_id
`ifdef DATA_CHK_VERIFIER_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DATA_BEATS);

  chk_state_t        state_reg, state_next;
  logic [DATA_W-1:0] h_data_reg;
  logic [KEEP_W-1:0] h_keep_reg;
  logic [ID_W-1:0]   h_id_reg;
  beat_t             o_reg;
  logic              o_valid_reg;
  logic [CHK_W-1:0]  acc_reg, acc_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic              ferr_reg, ferr_next;
  logic              status_valid_reg;
  logic              status_ok_reg;
  logic [ID_W-1:0]   status_id_reg;

  logic [CHK_W-1:0]  beat_sum;
  logic              accept;
  logic              load_h;
  logic              load_o;
  logic              status_fire;
  logic              status_ok_next;

  data_chk_sum512 u_sum (
    .data (in_data),
    .keep (in_keep),
    .sum  (beat_sum)
  );

  // O may take a new beat when it is empty or being drained this cycle.
  assign in_ready = !o_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state, accumulator and load decisions for each accepted beat.
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    ferr_next      = ferr_reg;
    load_h         = 1'b0;
    load_o         = 1'b0;
    status_fire    = 1'b0;
    status_ok_next = 1'b0;
    if (accept) begin
      if (!in_last) begin
        load_h     = 1'b1;
        state_next = ST_HOLD;
        if (state_reg == ST_EMPTY) begin
          acc_next  = beat_sum;
          cnt_next  = 3'd1;
          ferr_next = 1'b0;
        end else begin
          // Parked beat is not the last one: push it out with last=0.
          load_o   = 1'b1;
          acc_next = acc_reg + beat_sum;
          if (cnt_reg >= MAX_CNT) begin
            ferr_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
      end else begin
        // Checksum beat: close the segment whether or not data preceded it.
        status_fire    = 1'b1;
        status_ok_next = (state_reg == ST_HOLD) &&
                         (acc_reg == in_data[CHK_LSB +: CHK_W]) && !ferr_reg;
        load_o         = (state_reg == ST_HOLD);
        state_next     = ST_EMPTY;
        acc_next       = '0;
        cnt_next       = '0;
        ferr_next      = 1'b0;
      end
    end
  end

  // State, accumulator and hold-register updates.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg  <= ST_EMPTY;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      ferr_reg   <= 1'b0;
      h_data_reg <= '0;
      h_keep_reg <= '0;
      h_id_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ferr_reg  <= ferr_next;
      if (load_h) begin
        h_data_reg <= in_data;
        h_keep_reg <= in_keep;
        h_id_reg   <= in_id;
      end
    end
  end

  // Output register and status pulse; O holds until drained or reloaded.
  always_ff @(posedge clock) begin
    if (!reset) begin
      o_reg            <= '0;
      o_valid_reg      <= 1'b0;
      status_valid_reg <= 1'b0;
      status_ok_reg    <= 1'b0;
      status_id_reg    <= '0;
    end else begin
      if (load_o) begin
        o_reg.data  <= h_data_reg;
        o_reg.keep  <= h_keep_reg;
        o_reg.id    <= h_id_reg;
        o_reg.last  <= in_last;
        o_valid_reg <= 1'b1;
      end else if (out_ready) begin
        o_valid_reg <= 1'b0;
      end
      status_valid_reg <= status_fire;
      status_ok_reg    <= status_fire && status_ok_next;
      if (status_fire) begin
        status_id_reg <= in_id;
      end
    end
  end

  assign out_data     = o_reg.data;
  assign out_keep     = o_reg.keep;
  assign out_id       = o_reg.id;
  assign out_last     = o_reg.last;
  assign out_valid    = o_valid_reg;
  assign status_valid = status_valid_reg;
  assign status_ok    = status_ok_reg;
  assign status_id    = status_id_reg;

`ifdef DATA_CHK_VERIFIER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  // Saturating count of failed segments, updated with the status pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      err_cnt_reg <= '0;
    end else if (status_fire && !status_ok_next && (err_cnt_reg != '1)) begin
      err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_data_chk_verifier.sv
// Self-checking bench for data_chk_verifier: directed segments plus random
// segments/backpressure, checked every cycle against a segment-level model.
// Build with DATA_CHK_VERIFIER_ERR_CNT_EN to also check err_cnt.
module tb_data_chk_verifier;

  localparam int MAX_BEATS = 4;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic [5:0]   id;
    logic         last;
  } tb_beat_t;

  logic         clock;
  logic         reset;
  logic [511:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_keep;
  logic [5:0]   in_id;
  logic         in_last;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_keep;
  logic [5:0]   out_id;
  logic         out_last;
  logic         status_valid;
  logic         status_ok;
  logic [5:0]   status_id;
`ifdef DATA_CHK_VERIFIER_ERR_CNT_EN
  logic [15:0]  err_cnt;
  logic [15:0]  err_model;
`endif

  data_chk_verifier #(
    .MAX_DATA_BEATS(MAX_BEATS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_keep      (in_keep),
    .in_id        (in_id),
    .in_last      (in_last),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_keep     (out_keep),
    .out_id       (out_id),
    .out_last     (out_last),
    .status_valid (status_valid),
    .status_ok    (status_ok),
    .status_id    (status_id)
`ifdef DATA_CHK_VERIFIER_ERR_CNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  tb_beat_t     exp_q[$];
  tb_beat_t     hold_beat;
  bit           have_hold = 0;
  int           seg_n = 0;
  logic [31:0]  seg_sum = '0;
  bit           stat_pend = 0;
  logic         pend_ok = 1'b0;
  logic [5:0]   pend_id = '0;
  bit           load_pend = 0;
  bit           stall_pend = 0;
  tb_beat_t     stall_beat;

  // Observation counters used by the directed literal checks
  int           n_out = 0;
  int           n_last = 0;
  int           n_stat = 0;
  logic         last_ok = 1'b0;
  int           base_out = 0;
  int           base_stat = 0;

  int           rdy_mode = 0;
  int           rdy_phase = 0;

  task automatic check_n(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Checksum from the byte view: each kept byte weighted by its lane in its word.
  function automatic logic [31:0] model_sum(input logic [511:0] d, input logic [63:0] k);
    logic [31:0] s;
    s = '0;
    for (int b = 0; b < 64; b++) begin
      if (k[b]) s = s + ({24'h0, d[b*8 +: 8]} << (8 * (b % 4)));
    end
    return s;
  endfunction

  // Per-cycle compare and model advance, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      have_hold  = 0;
      seg_n      = 0;
      seg_sum    = '0;
      stat_pend  = 0;
      load_pend  = 0;
      stall_pend = 0;
`ifdef DATA_CHK_VERIFIER_ERR_CNT_EN
      err_model  = '0;
`endif
    end else begin
      check_n("status_valid", 64'(status_valid), 64'(stat_pend));
      if (stat_pend) begin
        check_n("status_ok", 64'(status_ok), 64'(pend_ok));
        check_n("status_id", 64'(status_id), 64'(pend_id));
        n_stat++;
        last_ok = status_ok;
`ifdef DATA_CHK_VERIFIER_ERR_CNT_EN
        if (!pend_ok && err_model != 16'hFFFF) err_model = err_model + 16'd1;
        check_n("err_cnt", 64'(err_cnt), 64'(err_model));
`endif
      end
      if (load_pend) check_n("out_valid_after_load", 64'(out_valid), 64'd1);
      if (stall_pend) begin
        check_n("stall_valid", 64'(out_valid), 64'd1);
        check_w("stall_data", out_data, stall_beat.data);
        check_n("stall_ctl", {out_keep, out_id, out_last},
                {stall_beat.keep, stall_beat.id, stall_beat.last});
      end
      check_n("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      stall_pend = out_valid && !out_ready;
      if (stall_pend) stall_beat = '{out_data, out_keep, out_id, out_last};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got beat id %0h last %0b, expected none", out_id, out_last);
        end else begin
          tb_beat_t e;
          e = exp_q.pop_front();
          check_w("out_data", out_data, e.data);
          check_n("out_ctl", {out_keep, out_id, out_last}, {e.keep, e.id, e.last});
          n_out++;
          if (out_last) n_last++;
        end
      end
      stat_pend = 0;
      load_pend = 0;
      if (in_valid && in_ready) begin
        if (!in_last) begin
          if (have_hold) begin
            exp_q.push_back(hold_beat);
            load_pend = 1;
          end
          hold_beat = '{in_data, in_keep, in_id, 1'b0};
          have_hold = 1;
          seg_n++;
          seg_sum = seg_sum + model_sum(in_data, in_keep);
        end else begin
          stat_pend = 1;
          pend_id   = in_id;
          pend_ok   = have_hold && (seg_n <= MAX_BEATS) && (seg_sum == in_data[31:0]);
          if (have_hold) begin
            hold_beat.last = 1'b1;
            exp_q.push_back(hold_beat);
            load_pend = 1;
          end
          have_hold = 0;
          seg_n     = 0;
          seg_sum   = '0;
        end
      end
    end
  end

  // Downstream backpressure: always ready, random, or the 1,0,0 pattern.
  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2: begin
        out_ready = (rdy_phase % 3 == 0);
        rdy_phase++;
      end
      default: out_ready = 1'b1;
    endcase
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [511:0] d, input logic [63:0] k, input logic [5:0] id,
                      input logic last);
    bit done;
    done     = 0;
    in_data  = d;
    in_keep  = k;
    in_id    = id;
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clock);
      if (in_ready) done = 1;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready low for 1000 cycles, expected acceptance");
    end
  endtask

  task automatic expect_seg(input string name, input int exp_out, input logic exp_ok);
    idle(8);
    check_n({name, "_out_beats"}, 64'(n_out - base_out), 64'(exp_out));
    check_n({name, "_status_cnt"}, 64'(n_stat - base_stat), 64'd1);
    check_n({name, "_status_ok"}, 64'(last_ok), 64'(exp_ok));
    $display("segment %s: out_beats=%0d status_ok=%0b", name, n_out - base_out, last_ok);
    base_out  = n_out;
    base_stat = n_stat;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  logic [511:0] ones_data;
  logic [511:0] mask_data;
  logic [63:0]  full_keep;

  initial begin
    ones_data = {16{32'h00000001}};
    mask_data = {{15{32'h12345678}}, 32'hFFFFFFFF};
    full_keep = '1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_keep   = '0;
    in_id     = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_n("rst_out_valid", 64'(out_valid), 64'd0);
    check_w("rst_out_data", out_data, '0);
    check_n("rst_out_ctl", {out_keep, out_id, out_last}, '0);
    check_n("rst_status", {status_valid, status_ok, status_id}, '0);
`ifdef DATA_CHK_VERIFIER_ERR_CNT_EN
    check_n("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Pin the model's checksum arithmetic with hand-computed values.
    check_n("model_sum_ones", 64'(model_sum(ones_data, full_keep)), 64'h10);
    check_n("model_sum_masked", 64'(model_sum(mask_data, 64'hF)), 64'hFFFFFFFF);

    // Good two-beat segment
    send(ones_data, full_keep, 6'd1, 1'b0);
    send(ones_data, full_keep, 6'd1, 1'b0);
    send(512'h20, '0, 6'd1, 1'b1);
    expect_seg("good2", 2, 1'b1);

    // Same segment, wrong checksum
    send(ones_data, full_keep, 6'd2, 1'b0);
    send(ones_data, full_keep, 6'd2, 1'b0);
    send(512'h21, '0, 6'd2, 1'b1);
    expect_seg("bad2", 2, 1'b0);
`ifdef DATA_CHK_VERIFIER_ERR_CNT_EN
    check_n("err_cnt_after_bad2", 64'(err_cnt), 64'd1);
`endif

    // Keep-masked single beat
    send(mask_data, 64'hF, 6'd3, 1'b0);
    send(512'hFFFFFFFF, '0, 6'd3, 1'b1);
    expect_seg("masked", 1, 1'b1);

    // Five data beats: framing error despite a correct sum
    for (int i = 0; i < 5; i++) send(ones_data, full_keep, 6'd4, 1'b0);
    base_stat = n_stat;
    n_last = 0;
    send(512'h50, '0, 6'd4, 1'b1);
    expect_seg("over5", 5, 1'b0);
    check_n("over5_last_count", 64'(n_last), 64'd1);

    // Checksum beat with no data
    send(512'h0, '0, 6'd5, 1'b1);
    expect_seg("empty", 0, 1'b0);

    // Four distinct beats under 1,0,0 backpressure
    rdy_mode  = 2;
    rdy_phase = 0;
    begin
      logic [31:0] s;
      logic [511:0] d;
      s = '0;
      for (int i = 0; i < 4; i++) begin
        d = rand512();
        s = s + model_sum(d, full_keep);
        send(d, full_keep, 6'(10 + i), 1'b0);
      end
      send({480'h0, s}, '0, 6'd14, 1'b1);
    end
    rdy_mode = 0;
    expect_seg("stall4", 4, 1'b1);

    // Reset after two data beats, then a fresh one-beat segment
    send(ones_data, full_keep, 6'd20, 1'b0);
    send(ones_data, full_keep, 6'd20, 1'b0);
    idle(3);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    check_n("reset_no_status", 64'(n_stat - base_stat), 64'd0);
    base_out  = n_out;
    base_stat = n_stat;
    send(ones_data, full_keep, 6'd21, 1'b0);
    send(512'h10, '0, 6'd21, 1'b1);
    expect_seg("post_reset", 1, 1'b1);

    // Random segments with random gaps and backpressure
    rdy_mode = 1;
    for (int seg = 0; seg < 60; seg++) begin
      int n;
      logic [31:0] s;
      logic [511:0] d;
      logic [63:0] k;
      logic [5:0] id;
      id = 6'($urandom);
      n  = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 6) : $urandom_range(0, MAX_BEATS);
      s  = '0;
      for (int b = 0; b < n; b++) begin
        d = rand512();
        k = ($urandom_range(0, 1) == 1) ? full_keep : {$urandom, $urandom};
        s = s + model_sum(d, k);
        send(d, k, id, 1'b0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      if ($urandom_range(0, 3) == 0) s = s ^ (32'h1 << $urandom_range(0, 31));
      send({rand512() >> 32, s}, {$urandom, $urandom}, id, 1'b1);
      $display("random segment %0d: id=%0h data_beats=%0d", seg, id, n);
    end
    rdy_mode = 0;
    idle(10);
    check_n("final_exp_queue_empty", 64'(exp_q.size()), 64'd0);
    check_n("final_no_held_beat", 64'(have_hold), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
